spi_controller: RTL and testbench
=================================

SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all sequential logic runs on the rising edge of cdac; no other signal is used as a clock.
REQ-002 Ports: cdac in 1 system clock (~7.09 MHz); _reset in 1 async active-low reset; cck in 1 and cckq in 1 Amiga phase clocks, kept for board compatibility and treated only as synchronous data inputs.
REQ-003 Ports: _as in 1 address strobe; _ds in 1 data strobe; r_w in 1 (1 = read).
REQ-004 Ports: adr_h in 6 (CPU A23:A18); adr_l in 4 (CPU A11:A8); data inout 8 (CPU D7:D0).
REQ-005 Ports: xrdy out 1 (1 = ready, 0 = insert wait states); miso in 1; mosi out 1; sclk out 1; _cs out 4 (active-low chip selects).

Function
REQ-006 Select = (adr_h == 6'h3B) && _as low, so the block answers at $EC0000-$EFFFFF; register index = adr_l[2:0], adr_l[3] ignored (mirror).
REQ-007 Register 0, read: shifter byte, no side effect.
REQ-008 Register 1, read: shifter byte; at access end (_as sampled high) load 8'hFF and start a transfer.
REQ-009 Register 2, write: load data byte into shifter and start a transfer; read returns shifter.
REQ-010 Register 3, select: _cs = ~bits[3:0]; readback returns bits[3:0].
REQ-011 Register 4, control: bits[1:0] speed, 00 = /32, 01 = /8, 1x = /2 (turbo), giving sclk periods of 32, 8 and 2 cdac cycles; read returns {busy, 5'b0, speed}.
REQ-012 Register 5, crc_source: any write clears CRC to 16'h0000 and latches bit0 as source (0 = MOSI, 1 = MISO).
REQ-013 Registers 6 and 7, read: CRC[15:8] and CRC[7:0]; writes ignored.
REQ-014 Bus inputs (_as, _ds, r_w) SHALL be sampled every clock.
REQ-015 A write commits once per access, on the first clock with _as, _ds and r_w all low while not busy.
REQ-016 data SHALL be driven only while selected with r_w high and _ds low; otherwise high-Z.
REQ-017 Any selected access while a transfer is busy SHALL hold xrdy low until the transfer completes, then complete normally; otherwise xrdy = 1.
REQ-018 Transfer is SPI mode 0, MSB first, 8 bits; sclk idles low; mosi = shifter[7] set up before each rising edge; miso shifted into shifter[0] on each rising edge; shift on each falling edge.
REQ-019 After 8 bits the shifter holds the received byte and busy clears; mosi idles high.
REQ-020 CRC SHALL be CRC16-CCITT (poly 0x1021, MSB first), updated on every sclk rising edge with the selected source bit.
REQ-021 A speed change SHALL take effect at the next transfer start.

Reset
REQ-022 _reset low SHALL asynchronously abort any transfer and set: _cs = 4'hF, sclk = 0, mosi = 1, xrdy = 1, data high-Z, shifter = 8'hFF, speed = 00, busy = 0, CRC = 0, source = MOSI.

Configuration
REQ-023 SPI_CONTROLLER_CRC_EN defined: registers 5-7 behave as specified above.
REQ-024 SPI_CONTROLLER_CRC_EN undefined: no CRC logic; registers 5-7 read 8'h00 and writes to them are ignored.

Structure
REQ-025 Package spi_controller_pkg SHALL hold register index constants, speed encodings, divider values, CRC polynomial and the base address 6'h3B.
REQ-026 One sub-module, spi_crc16, SHALL implement the bit-serial CRC (clear, enable, bit in, 16-bit out).

Verification
REQ-027 Turbo read: control=2, select=1, write reg2=FF, read reg1 x3, read reg0, miso stream DEADBEEF -> bytes DE AD BE EF, _cs = 4'b1110 during the access.
REQ-028 Slow read: control=0, miso stream ABBA1234 -> bytes AB BA 12 34; xrdy low while busy.
REQ-029 Slow write of 12,34,56,78 on reg2 -> mosi bits captured on sclk rising edges = 32'h12345678; select=0 -> _cs = 4'hF.
REQ-030 Turbo write of 9A,BC,DE,F0 -> captured 32'h9ABCDEF0.
REQ-031 CRC test: write reg5=0, write reg2=FF 512 times, read reg6/reg7 with no dummy access -> 8'h7F / 8'hA1.
REQ-032 Reset asserted mid-transfer -> sclk=0, _cs=4'hF, xrdy=1 immediately; next access completes without wait.

Source files
------------

// File: rtl/spi_controller_pkg.sv
// Shared constants and types for the SPI controller.
package spi_controller_pkg;

  // Block decodes CPU A23:A18 == 6'h3B ($EC0000-$EFFFFF)
  localparam logic [5:0] BASE_ADR = 6'h3B;

  // Register indices (adr_l[2:0])
  localparam logic [2:0] REG_STAT    = 3'd0;
  localparam logic [2:0] REG_RX      = 3'd1;
  localparam logic [2:0] REG_DATA    = 3'd2;
  localparam logic [2:0] REG_SEL     = 3'd3;
  localparam logic [2:0] REG_CTRL    = 3'd4;
  localparam logic [2:0] REG_CRC_SRC = 3'd5;
  localparam logic [2:0] REG_CRC_HI  = 3'd6;
  localparam logic [2:0] REG_CRC_LO  = 3'd7;

  // Speed encodings; any value with bit 1 set selects turbo
  localparam logic [1:0] SPEED_DIV32 = 2'b00;
  localparam logic [1:0] SPEED_DIV8  = 2'b01;
  localparam logic [1:0] SPEED_TURBO = 2'b10;

  // sclk period in cdac cycles for each speed
  localparam int unsigned DIV_SLOW  = 32;
  localparam int unsigned DIV_MED   = 8;
  localparam int unsigned DIV_TURBO = 2;

  // Half-period counter width (largest load is DIV_SLOW/2-1)
  localparam int unsigned CNT_W = 4;

  // CRC16-CCITT polynomial
  localparam logic [15:0] CRC_POLY = 16'h1021;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } xfer_state_t;

  // Counter reload value for one sclk half period
  function automatic logic [CNT_W-1:0] half_load(input logic [1:0] spd);
    logic [CNT_W-1:0] ld;
    if ((spd & SPEED_TURBO) != 2'b00) begin
      ld = CNT_W'(DIV_TURBO / 2 - 1);
    end else if (spd == SPEED_DIV32) begin
      ld = CNT_W'(DIV_SLOW / 2 - 1);
    end else begin
      ld = CNT_W'(DIV_MED / 2 - 1);
    end
    return ld;
  endfunction

endpackage

// File: rtl/spi_crc16.sv
// Bit-serial CRC16-CCITT, MSB first, synchronous clear.
module spi_crc16
  import spi_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  // CRC register: clear wins over update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 16'h0000;
    end else if (clr) begin
      crc <= 16'h0000;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/spi_controller.sv
// Zorro-style SPI master: 8-bit mode-0 shifter, 4 chip selects, three speeds.
// Optional CRC16 on registers 5-7 enabled by defining SPI_CONTROLLER_CRC_EN.
module spi_controller
  import spi_controller_pkg::*;
(
  input  logic       cdac,
  input  logic       _reset,
  input  logic       cck,
  input  logic       cckq,
  input  logic       _as,
  input  logic       _ds,
  input  logic       r_w,
  input  logic [5:0] adr_h,
  input  logic [3:0] adr_l,
  inout  wire  [7:0] data,
  output logic       xrdy,
  input  logic       miso,
  output logic       mosi,
  output logic       sclk,
  output logic [3:0] _cs
);

  xfer_state_t      state, state_n;
  logic             as_s, ds_s, rw_s, cck_s, cckq_s;
  logic             acc_done, wr_done, r1_pend;
  logic             data_oe;
  logic [7:0]       rd_data, rd_mux_c;
  logic [7:0]       shifter;
  logic [1:0]       speed;
  logic [CNT_W-1:0] cnt, half_q;
  logic [2:0]       bit_cnt;
  logic             miso_q;
  logic             sel_c, busy_c, wr_c, r1_start_c, start_c, rise_c, fall_c;
  logic [7:0]       start_byte_c;
  logic [2:0]       idx_c;
  logic             unused_c;

  // Phase clocks and the mirror address bit carry no function here
  assign unused_c = ^{cck_s, cckq_s, adr_l[3]};

  assign idx_c        = adr_l[2:0];
  assign sel_c        = (adr_h == BASE_ADR) && !as_s;
  assign busy_c       = (state != ST_IDLE);
  assign wr_c         = sel_c && !ds_s && !rw_s && !busy_c && !wr_done;
  assign r1_start_c   = r1_pend && as_s && !busy_c;
  assign start_c      = r1_start_c || (wr_c && (idx_c == REG_DATA));
  assign start_byte_c = r1_start_c ? 8'hFF : data;

  assign data = data_oe ? rd_data : 8'hzz;

  // Sample bus strobes and phase clocks every cycle
  always_ff @(posedge cdac or negedge _reset) begin
    if (!_reset) begin
      as_s   <= 1'b1;
      ds_s   <= 1'b1;
      rw_s   <= 1'b1;
      cck_s  <= 1'b0;
      cckq_s <= 1'b0;
    end else begin
      as_s   <= _as;
      ds_s   <= _ds;
      rw_s   <= r_w;
      cck_s  <= cck;
      cckq_s <= cckq;
    end
  end

  // Per-access bookkeeping: accepted flag, one-shot write, deferred reg1 start
  always_ff @(posedge cdac or negedge _reset) begin
    if (!_reset) begin
      acc_done <= 1'b0;
      wr_done  <= 1'b0;
      r1_pend  <= 1'b0;
    end else begin
      if (as_s) begin
        acc_done <= 1'b0;
        wr_done  <= 1'b0;
      end else begin
        if (sel_c && !busy_c) acc_done <= 1'b1;
        if (wr_c)             wr_done  <= 1'b1;
      end
      if (r1_start_c) begin
        r1_pend <= 1'b0;
      end else if (sel_c && rw_s && !busy_c && (idx_c == REG_RX)) begin
        r1_pend <= 1'b1;
      end
    end
  end

  // Wait-state and data-bus drive
  always_ff @(posedge cdac or negedge _reset) begin
    if (!_reset) begin
      xrdy    <= 1'b1;
      data_oe <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      xrdy    <= !(sel_c && busy_c && !acc_done);
      data_oe <= sel_c && rw_s && !ds_s;
      rd_data <= rd_mux_c;
    end
  end

  // Chip-select and speed registers
  always_ff @(posedge cdac or negedge _reset) begin
    if (!_reset) begin
      _cs   <= 4'hF;
      speed <= SPEED_DIV32;
    end else if (wr_c) begin
      if (idx_c == REG_SEL)  _cs   <= ~data[3:0];
      if (idx_c == REG_CTRL) speed <= data[1:0];
    end
  end

`ifdef SPI_CONTROLLER_CRC_EN
  logic        crc_src, crc_clr_c, crc_bit_c;
  logic [15:0] crc;

  assign crc_clr_c = wr_c && (idx_c == REG_CRC_SRC);
  assign crc_bit_c = crc_src ? miso : shifter[7];

  // CRC source select, latched on any reg5 write
  always_ff @(posedge cdac or negedge _reset) begin
    if (!_reset) begin
      crc_src <= 1'b0;
    end else if (crc_clr_c) begin
      crc_src <= data[0];
    end
  end

  spi_crc16 u_crc (
    .clk    (cdac),
    .rst_n  (_reset),
    .clr    (crc_clr_c),
    .en     (rise_c),
    .bit_in (crc_bit_c),
    .crc    (crc)
  );
`endif

  // Register readback mux
  always_comb begin
    rd_mux_c = shifter;
    case (idx_c)
      REG_STAT, REG_RX, REG_DATA: rd_mux_c = shifter;
      REG_SEL:     rd_mux_c = {4'h0, ~_cs};
      REG_CTRL:    rd_mux_c = {busy_c, 5'b00000, speed};
`ifdef SPI_CONTROLLER_CRC_EN
      REG_CRC_SRC: rd_mux_c = {7'b0000000, crc_src};
      REG_CRC_HI:  rd_mux_c = crc[15:8];
      REG_CRC_LO:  rd_mux_c = crc[7:0];
`else
      REG_CRC_SRC, REG_CRC_HI, REG_CRC_LO: rd_mux_c = 8'h00;
`endif
      default:     rd_mux_c = shifter;
    endcase
  end

  // Transfer FSM state register
  always_ff @(posedge cdac or negedge _reset) begin
    if (!_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Transfer FSM next state and sclk edge strobes
  always_comb begin
    state_n = state;
    rise_c  = 1'b0;
    fall_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_c) state_n = ST_LOW;
      end
      ST_LOW: begin
        if (cnt == '0) begin
          rise_c  = 1'b1;
          state_n = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (cnt == '0) begin
          fall_c  = 1'b1;
          state_n = (bit_cnt == 3'd7) ? ST_IDLE : ST_LOW;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Shift datapath: sample miso on rise, shift and present next mosi on fall
  always_ff @(posedge cdac or negedge _reset) begin
    if (!_reset) begin
      shifter <= 8'hFF;
      mosi    <= 1'b1;
      sclk    <= 1'b0;
      cnt     <= '0;
      half_q  <= '0;
      bit_cnt <= 3'd0;
      miso_q  <= 1'b0;
    end else if (start_c) begin
      shifter <= start_byte_c;
      mosi    <= start_byte_c[7];
      cnt     <= half_load(speed);
      half_q  <= half_load(speed);
      bit_cnt <= 3'd0;
    end else if (rise_c) begin
      sclk    <= 1'b1;
      miso_q  <= miso;
      cnt     <= half_q;
    end else if (fall_c) begin
      sclk    <= 1'b0;
      shifter <= {shifter[6:0], miso_q};
      bit_cnt <= bit_cnt + 3'd1;
      cnt     <= half_q;
      mosi    <= (bit_cnt == 3'd7) ? 1'b1 : shifter[6];
    end else if (busy_c && (cnt != '0)) begin
      cnt     <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Directed self-checking bench for spi_controller (honours SPI_CONTROLLER_CRC_EN).
module tb_spi_controller;

  localparam int WAIT_LIMIT = 2000;

  logic       cdac = 1'b0;
  logic       _reset = 1'b1;
  logic       cck = 1'b0;
  logic       cckq = 1'b0;
  logic       _as = 1'b1;
  logic       _ds = 1'b1;
  logic       r_w = 1'b1;
  logic [5:0] adr_h = 6'h00;
  logic [3:0] adr_l = 4'h0;
  wire  [7:0] data;
  logic       xrdy;
  logic       miso;
  logic       mosi;
  logic       sclk;
  logic [3:0] _cs;

  logic       drv_en = 1'b0;
  logic [7:0] drv_data = 8'h00;
  assign data = drv_en ? drv_data : 8'hzz;

  int checks = 0;
  int failures = 0;

  // Slave model state
  int          neg_cnt = 0;
  int          base = 0;
  logic [31:0] stream = 32'hFFFFFFFF;
  logic [31:0] cap = 32'h0;
  time         rise_t = 0;
  time         rise_prev = 0;

  spi_controller u_dut (
    .cdac   (cdac),
    ._reset (_reset),
    .cck    (cck),
    .cckq   (cckq),
    ._as    (_as),
    ._ds    (_ds),
    .r_w    (r_w),
    .adr_h  (adr_h),
    .adr_l  (adr_l),
    .data   (data),
    .xrdy   (xrdy),
    .miso   (miso),
    .mosi   (mosi),
    .sclk   (sclk),
    ._cs    (_cs)
  );

  always #5 cdac = ~cdac;

  always @(posedge cdac) begin
    cck  <= ~cck;
    cckq <= cck;
  end

  // Slave presents stream MSB first, advancing on each falling sclk
  always @(negedge sclk) neg_cnt <= neg_cnt + 1;

  always_comb begin
    int k;
    k = neg_cnt - base;
    miso = (k >= 0 && k < 32) ? stream[31 - k] : 1'b1;
  end

  // Capture mosi and timestamp on rising sclk
  always @(posedge sclk) begin
    cap       <= {cap[30:0], mosi};
    rise_prev <= rise_t;
    rise_t    <= $time;
  end

  task automatic bus_access(input logic rw, input logic [5:0] ah, input logic [3:0] al,
                            input logic [7:0] wd, output logic [7:0] rd, output int waits,
                            output logic [3:0] cs_obs);
    @(negedge cdac);
    adr_h = ah; adr_l = al; r_w = rw; drv_data = wd; drv_en = !rw;
    _as = 1'b0; _ds = 1'b0;
    @(posedge cdac);
    @(posedge cdac);
    @(negedge cdac);
    waits = 0;
    while (xrdy !== 1'b1 && waits < WAIT_LIMIT) begin
      waits++;
      @(negedge cdac);
    end
    if (waits >= WAIT_LIMIT) begin
      checks++; failures++;
      $display("FAIL bus_timeout reg=%0d xrdy=%b required=1", al, xrdy);
    end
    rd = data;
    cs_obs = _cs;
    _as = 1'b1; _ds = 1'b1; r_w = 1'b1; drv_en = 1'b0; adr_h = 6'h00;
    @(negedge cdac);
  endtask

  task automatic reg_wr(input logic [3:0] al, input logic [7:0] wd);
    logic [7:0] rd; int w; logic [3:0] cs;
    bus_access(1'b0, 6'h3B, al, wd, rd, w, cs);
  endtask

  task automatic reg_rd(input logic [3:0] al, output logic [7:0] rd, output int w,
                        output logic [3:0] cs);
    bus_access(1'b1, 6'h3B, al, 8'h00, rd, w, cs);
  endtask

  task automatic test_reset();
    logic [7:0] rd; int w; logic [3:0] cs;
    #2 _reset = 1'b0;
    #1;
    checks++; if (_cs !== 4'hF) begin failures++; $display("FAIL rst_cs got=%h exp=F", _cs); end
    checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL rst_sclk got=%b exp=0", sclk); end
    checks++; if (mosi !== 1'b1) begin failures++; $display("FAIL rst_mosi got=%b exp=1", mosi); end
    checks++; if (xrdy !== 1'b1) begin failures++; $display("FAIL rst_xrdy got=%b exp=1", xrdy); end
    repeat (3) @(negedge cdac);
    _reset = 1'b1;
    reg_rd(4'd0, rd, w, cs);
    checks++; if (rd !== 8'hFF) begin failures++; $display("FAIL rst_shifter got=%h exp=FF", rd); end
    reg_rd(4'd4, rd, w, cs);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL rst_ctrl got=%h exp=00", rd); end
    reg_rd(4'd3, rd, w, cs);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL rst_select got=%h exp=00", rd); end
  endtask

  task automatic test_turbo_read();
    logic [7:0] rd; int w; logic [3:0] cs;
    reg_wr(4'd4, 8'h02);
    reg_wr(4'd3, 8'h01);
    base = neg_cnt; stream = 32'hDEADBEEF;
    reg_wr(4'd2, 8'hFF);
    reg_rd(4'd1, rd, w, cs);
    checks++; if (rd !== 8'hDE) begin failures++; $display("FAIL turbo_rd0 got=%h exp=DE", rd); end
    checks++; if (cs !== 4'b1110) begin failures++; $display("FAIL turbo_cs got=%b exp=1110", cs); end
    reg_rd(4'd1, rd, w, cs);
    checks++; if (rd !== 8'hAD) begin failures++; $display("FAIL turbo_rd1 got=%h exp=AD", rd); end
    reg_rd(4'd1, rd, w, cs);
    checks++; if (rd !== 8'hBE) begin failures++; $display("FAIL turbo_rd2 got=%h exp=BE", rd); end
    reg_rd(4'd8, rd, w, cs);  // mirror of reg0
    checks++; if (rd !== 8'hEF) begin failures++; $display("FAIL turbo_rd3 got=%h exp=EF", rd); end
  endtask

  task automatic test_slow_read();
    logic [7:0] rd; int w; logic [3:0] cs;
    reg_wr(4'd4, 8'h00);
    base = neg_cnt; stream = 32'hABBA1234;
    reg_wr(4'd2, 8'hFF);
    reg_rd(4'd1, rd, w, cs);
    checks++; if (rd !== 8'hAB) begin failures++; $display("FAIL slow_rd0 got=%h exp=AB", rd); end
    checks++; if (w == 0) begin failures++; $display("FAIL slow_xrdy_wait got=%0d exp=>0", w); end
    reg_rd(4'd1, rd, w, cs);
    checks++; if (rd !== 8'hBA) begin failures++; $display("FAIL slow_rd1 got=%h exp=BA", rd); end
    reg_rd(4'd1, rd, w, cs);
    checks++; if (rd !== 8'h12) begin failures++; $display("FAIL slow_rd2 got=%h exp=12", rd); end
    reg_rd(4'd0, rd, w, cs);
    checks++; if (rd !== 8'h34) begin failures++; $display("FAIL slow_rd3 got=%h exp=34", rd); end
    checks++; if (w == 0) begin failures++; $display("FAIL slow_rd3_wait got=%0d exp=>0", w); end
  endtask

  task automatic test_slow_write();
    logic [7:0] rd; int w; logic [3:0] cs;
    reg_wr(4'd2, 8'h12);
    reg_wr(4'd2, 8'h34);
    reg_wr(4'd2, 8'h56);
    reg_wr(4'd2, 8'h78);
    reg_rd(4'd0, rd, w, cs);
    checks++; if (cap !== 32'h12345678) begin failures++; $display("FAIL slow_wr_mosi got=%h exp=12345678", cap); end
    checks++; if (rise_t - rise_prev !== 320) begin failures++; $display("FAIL slow_period got=%0t exp=320", rise_t - rise_prev); end
    reg_wr(4'd3, 8'h00);
    checks++; if (_cs !== 4'hF) begin failures++; $display("FAIL desel_cs got=%h exp=F", _cs); end
  endtask

  task automatic test_unselected();
    logic [7:0] rd; int w; logic [3:0] cs;
    bus_access(1'b0, 6'h3A, 4'd3, 8'h0F, rd, w, cs);
    checks++; if (_cs !== 4'hF) begin failures++; $display("FAIL unsel_cs got=%h exp=F", _cs); end
    reg_rd(4'd3, rd, w, cs);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL unsel_select got=%h exp=00", rd); end
  endtask

  task automatic test_mid_speed();
    logic [7:0] rd; int w; logic [3:0] cs;
    reg_wr(4'd4, 8'h01);
    reg_wr(4'd2, 8'hA5);
    reg_rd(4'd0, rd, w, cs);
    checks++; if (cap[7:0] !== 8'hA5) begin failures++; $display("FAIL mid_mosi got=%h exp=A5", cap[7:0]); end
    checks++; if (rise_t - rise_prev !== 80) begin failures++; $display("FAIL mid_period got=%0t exp=80", rise_t - rise_prev); end
  endtask

  task automatic test_turbo_write();
    logic [7:0] rd; int w; logic [3:0] cs;
    reg_wr(4'd4, 8'h03);
    reg_wr(4'd2, 8'h9A);
    reg_wr(4'd2, 8'hBC);
    reg_wr(4'd2, 8'hDE);
    reg_wr(4'd2, 8'hF0);
    reg_rd(4'd4, rd, w, cs);
    checks++; if (rd !== 8'h03) begin failures++; $display("FAIL turbo_ctrl got=%h exp=03", rd); end
    checks++; if (cap !== 32'h9ABCDEF0) begin failures++; $display("FAIL turbo_wr_mosi got=%h exp=9ABCDEF0", cap); end
    checks++; if (rise_t - rise_prev !== 20) begin failures++; $display("FAIL turbo_period got=%0t exp=20", rise_t - rise_prev); end
  endtask

  task automatic test_crc();
    logic [7:0] rd; int w; logic [3:0] cs;
    reg_wr(4'd4, 8'h02);
`ifdef SPI_CONTROLLER_CRC_EN
    reg_wr(4'd5, 8'h00);
    for (int i = 0; i < 512; i++) reg_wr(4'd2, 8'hFF);
    reg_rd(4'd6, rd, w, cs);
    checks++; if (rd !== 8'h7F) begin failures++; $display("FAIL crc_hi got=%h exp=7F", rd); end
    reg_rd(4'd7, rd, w, cs);
    checks++; if (rd !== 8'hA1) begin failures++; $display("FAIL crc_lo got=%h exp=A1", rd); end
    reg_rd(4'd5, rd, w, cs);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL crc_src got=%h exp=00", rd); end
`else
    reg_wr(4'd5, 8'h01);
    reg_wr(4'd2, 8'h5A);
    reg_rd(4'd5, rd, w, cs);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL nocrc_r5 got=%h exp=00", rd); end
    reg_rd(4'd6, rd, w, cs);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL nocrc_r6 got=%h exp=00", rd); end
    reg_rd(4'd7, rd, w, cs);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL nocrc_r7 got=%h exp=00", rd); end
`endif
  endtask

  task automatic test_reset_mid_transfer();
    logic [7:0] rd; int w; logic [3:0] cs; int n;
    reg_wr(4'd4, 8'h00);
    reg_wr(4'd3, 8'h01);
    reg_wr(4'd2, 8'h55);
    n = 0;
    while (sclk !== 1'b1 && n < 200) begin
      n++;
      @(negedge cdac);
    end
    checks++; if (n >= 200) begin failures++; $display("FAIL mid_sclk_timeout sclk=%b exp=1", sclk); end
    #2 _reset = 1'b0;
    #1;
    checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL abort_sclk got=%b exp=0", sclk); end
    checks++; if (_cs !== 4'hF) begin failures++; $display("FAIL abort_cs got=%h exp=F", _cs); end
    checks++; if (xrdy !== 1'b1) begin failures++; $display("FAIL abort_xrdy got=%b exp=1", xrdy); end
    checks++; if (mosi !== 1'b1) begin failures++; $display("FAIL abort_mosi got=%b exp=1", mosi); end
    repeat (3) @(negedge cdac);
    _reset = 1'b1;
    reg_rd(4'd0, rd, w, cs);
    checks++; if (w != 0) begin failures++; $display("FAIL post_abort_wait got=%0d exp=0", w); end
    checks++; if (rd !== 8'hFF) begin failures++; $display("FAIL post_abort_shifter got=%h exp=FF", rd); end
  endtask

  initial begin
    test_reset();
    test_turbo_read();
    test_slow_read();
    test_slow_write();
    test_unselected();
    test_mid_speed();
    test_turbo_write();
    test_crc();
    test_reset_mid_transfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
